// File: rtl/div_pkg.sv
// div_pkg: shared state type and constants for the sequential divider
package div_pkg;
  typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;
  localparam int DEF_WIDTH = 16;
  localparam logic [63:0] Q_ONES = '1;
endpackage

// File: rtl/div_control.sv
// div_control: start/done handshake controller for the shift-subtract divider
module div_control
  import div_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic div_zero,
  input  logic cnt_zero,
  output logic load,
  output logic shift,
  output logic fin,
  output logic busy,
  output logic done
);
  state_t state;
  assign load  = state == IDLE && start;
  assign shift = state == ITER;
  assign fin   = shift && cnt_zero;
  // Sequence IDLE -> ITER -> FIN (or straight to FIN on divide-by-zero) with registered busy/done
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= load ? (div_zero ? FIN : ITER) : fin ? FIN : state == FIN ? IDLE : state;
      busy  <= (load && !div_zero) || (shift && !cnt_zero);
      done  <= (load && div_zero) || fin;
    end
endmodule

// File: rtl/div_seq.sv
// div_seq: restoring unsigned divider, one quotient bit per clock
module div_seq
  import div_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  logic [WIDTH-1:0] r, q, b, r_nxt, q_nxt;
  logic [CNT_W-1:0] count;
  logic [WIDTH:0]   sh, trial;
  logic             load, shift, fin, div_zero, cnt_zero;
  assign div_zero = divisor == '0;
  assign cnt_zero = count == CNT_W'(1);
  // The shifted remainder carries one extra bit so a divisor with its MSB set cannot overflow the trial
  always_comb begin
    sh    = {r, q[WIDTH-1]};
    trial = sh - {1'b0, b};
    r_nxt = trial[WIDTH] ? sh[WIDTH-1:0] : trial[WIDTH-1:0];
    q_nxt = {q[WIDTH-2:0], ~trial[WIDTH]};
  end
  div_control u_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .div_zero (div_zero),
    .cnt_zero (cnt_zero),
    .load     (load),
    .shift    (shift),
    .fin      (fin),
    .busy     (busy),
    .done     (done)
  );
  // Operand capture, shift-subtract iteration and result registers held until the next accept
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r           <= '0;
      q           <= '0;
      b           <= '0;
      count       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (load && div_zero) begin
      quotient    <= Q_ONES[WIDTH-1:0];
      remainder   <= dividend;
      div_by_zero <= 1'b1;
    end else if (load) begin
      b           <= divisor;
      r           <= '0;
      q           <= dividend;
      count       <= CNT_W'(WIDTH);
      div_by_zero <= 1'b0;
    end else if (shift) begin
      r     <= r_nxt;
      q     <= q_nxt;
      count <= count - 1'b1;
      if (fin) begin
        quotient  <= q_nxt;
        remainder <= r_nxt;
      end
    end
endmodule
